// File: rtl/ext_unit_pipe_pkg.sv
// Shared definitions for the extension unit: operation codes and the
// byte-offset width helper used by the interface, core and top.
package ext_pkg;

  localparam logic [2:0] EXT_SEXT = 3'd0;  // sign-extend immediate
  localparam logic [2:0] EXT_ZEXT = 3'd1;  // zero-extend immediate
  localparam logic [2:0] EXT_LUI  = 3'd2;  // immediate in upper bits
  localparam logic [2:0] EXT_BOFF = 3'd3;  // sign-extended immediate << 2
  localparam logic [2:0] EXT_LB   = 3'd4;  // load byte, signed
  localparam logic [2:0] EXT_LBU  = 3'd5;  // load byte, unsigned
  localparam logic [2:0] EXT_LH   = 3'd6;  // load halfword, signed
  localparam logic [2:0] EXT_LHU  = 3'd7;  // load halfword, unsigned

  // Width of a byte offset into an OUT_W-bit word.
  function automatic int ext_off_w(input int out_w);
    return $clog2(out_w / 8);
  endfunction

endpackage

// File: rtl/ext_unit_pipe_if.sv
// Handshake bundle for ext_unit_pipe.
//   in_*  : producer -> unit beat (valid/ready, mode, data, byte offset)
//   out_* : unit -> consumer result (valid/ready, data, misalignment flag)
// master = upstream/downstream environment, slave = the unit itself.
interface ext_unit_pipe_if
  import ext_pkg::*;
#(
  parameter int OUT_W = 32
) ();
  localparam int OFF_W = ext_off_w(OUT_W);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_mode;
  logic [OUT_W-1:0] in_data;
  logic [OFF_W-1:0] in_off;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_data, in_off, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_off, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_unit_pipe_core.sv
// ext_core: combinational extension datapath.
//   i_mode   : operation select (EXT_* codes)
//   i_data   : immediate in low IN_W bits, or full load word
//   i_off    : little-endian byte offset for load modes
//   o_result : extended result
//   o_err    : misaligned halfword (result forced to zero)
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFF_W = ext_off_w(OUT_W)
) (
  input  logic [2:0]       i_mode,
  input  logic [OUT_W-1:0] i_data,
  input  logic [OFF_W-1:0] i_off,
  output logic [OUT_W-1:0] o_result,
  output logic             o_err
);
  logic [IN_W-1:0]  w_imm;
  logic [OUT_W-1:0] w_sext;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_mis;

  assign w_imm  = i_data[IN_W-1:0];
  assign w_sext = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
  assign w_byte = 8'(i_data >> {i_off, 3'b000});
  assign w_half = 16'(i_data >> {i_off, 3'b000});
  // Odd offsets, and a halfword starting in the last byte, are faults.
  assign w_mis  = i_off[0] || (i_off == OFF_W'(OUT_W/8 - 1));

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_mode)
      EXT_SEXT: o_result = w_sext;
      EXT_ZEXT: o_result = {{(OUT_W-IN_W){1'b0}}, w_imm};
      EXT_LUI:  o_result = {w_imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BOFF: o_result = w_sext << 2;
      EXT_LB:   o_result = {{(OUT_W-8){w_byte[7]}}, w_byte};
      EXT_LBU:  o_result = {{(OUT_W-8){1'b0}}, w_byte};
      EXT_LH, EXT_LHU: begin
        if (w_mis) begin
          o_err = 1'b1;
        end else if (i_mode == EXT_LH) begin
          o_result = {{(OUT_W-16){w_half[15]}}, w_half};
        end else begin
          o_result = {{(OUT_W-16){1'b0}}, w_half};
        end
      end
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered extension unit with a one-entry skid buffer.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave side of ext_unit_pipe_if (input beat / output result)
//   err_count : saturating count of accepted misaligned beats
// IN_W must lie in 1..OUT_W-2; OUT_W must be a multiple of 16.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  ext_unit_pipe_if.slave      bus,
  output logic [ERRCNT_W-1:0] err_count
);
  localparam int OFF_W = ext_off_w(OUT_W);

  logic [OUT_W-1:0]    w_result;
  logic                w_err;
  logic                w_acc;
  logic                w_drain;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_err;
  logic                r_skid_valid;
  logic [OUT_W-1:0]    r_skid_data;
  logic                r_skid_err;
  logic [ERRCNT_W-1:0] r_err_count;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .OFF_W(OFF_W)) u_core (
    .i_mode   (bus.in_mode),
    .i_data   (bus.in_data),
    .i_off    (bus.in_off),
    .o_result (w_result),
    .o_err    (w_err)
  );

  // Ready depends only on registered state and rst, never on out_ready.
  assign bus.in_ready  = !rst && !r_skid_valid;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_drain       = r_out_valid && bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
  assign err_count     = r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      // A full skid implies in_ready=0, so no accept can coincide with it.
      if (w_drain && r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_acc && (!r_out_valid || w_drain)) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_err   <= w_err;
      end else if (w_acc) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_result;
        r_skid_err   <= w_err;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_acc && w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERRCNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ext_unit_pipe.sv
module tb_ext_unit_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  bit last_acc = 0;
  logic [1:0]  err_model = '0;
  logic [32:0] sb[$];

  ext_unit_pipe_if #(.OUT_W(32)) bus ();

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .ERRCNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Reference model: returns {err, data}.
  function automatic logic [32:0] model(input logic [2:0] m, input logic [31:0] d,
                                        input logic [1:0] o);
    logic [15:0] imm;
    logic [7:0]  b;
    logic [15:0] h;
    imm = d[15:0];
    b   = d[8*o +: 8];
    h   = (o == 2'd3) ? 16'h0 : d[8*o +: 16];
    case (m)
      3'd0: return {1'b0, {16{imm[15]}}, imm};
      3'd1: return {1'b0, 16'h0, imm};
      3'd2: return {1'b0, imm, 16'h0};
      3'd3: return {1'b0, {14{imm[15]}}, imm, 2'b00};
      3'd4: return {1'b0, {24{b[7]}}, b};
      3'd5: return {1'b0, 24'h0, b};
      3'd6: return (o == 2'd1 || o == 2'd3) ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
      default: return (o == 2'd1 || o == 2'd3) ? {1'b1, 32'h0} : {1'b0, 16'h0, h};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle just before the rising edge, then advance to the next
  // falling edge where new stimulus is driven.
  task automatic tick();
    logic [32:0] e;
    #4;
    last_acc = 0;
    if (rst) begin
      sb.delete();
    end else begin
      chk("out_valid_vs_sb", 64'(bus.out_valid), 64'(sb.size() != 0));
      chk("err_count", 64'(err_count), 64'(err_model));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
          chk("out_err", 64'(bus.out_err), 64'(e[32]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.in_mode, bus.in_data, bus.in_off);
        sb.push_back(e);
        if (e[32] && err_model != 2'b11) err_model = err_model + 2'd1;
        acc_cnt++;
        last_acc = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] m, input logic [31:0] d, input logic [1:0] o);
    int n;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_off   = o;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 10);
    if (!last_acc) chk("send_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] held;
    int acc0;
    int cyc;
    bit did_rst;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 3'd0;
    bus.in_data   = '0;
    bus.in_off    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Immediate modes, with explicit latency check on the first
    send(3'd0, 32'h0000_8001, 2'd0);
    chk("sext_lat_valid", 64'(bus.out_valid), 64'(1));
    chk("sext_value", 64'(bus.out_data), 64'h0000_0000_FFFF_8001);
    send(3'd1, 32'h0000_8001, 2'd0);
    send(3'd2, 32'h0000_8001, 2'd0);
    send(3'd3, 32'h0000_FFFF, 2'd0);
    // Load modes
    send(3'd4, 32'h80FF_7F01, 2'd1);
    send(3'd4, 32'h80FF_7F01, 2'd3);
    send(3'd5, 32'h80FF_7F01, 2'd2);
    send(3'd6, 32'h80FF_7F01, 2'd2);
    send(3'd7, 32'h80FF_7F01, 2'd0);
    drain();
    chk("zext_model", 64'(model(3'd1, 32'h8001, 2'd0)), 64'h0_0000_8001);

    // Misaligned halfwords and err_count saturation (ERRCNT_W=2)
    chk("err0", 64'(err_count), 64'(0));
    send(3'd6, 32'h80FF_7F01, 2'd1);
    chk("err1", 64'(err_count), 64'(1));
    send(3'd6, 32'h80FF_7F01, 2'd3);
    chk("err2", 64'(err_count), 64'(2));
    send(3'd7, 32'h1234_5678, 2'd1);
    send(3'd7, 32'h1234_5678, 2'd3);
    send(3'd6, 32'hFFFF_FFFF, 2'd1);
    chk("err_sat", 64'(err_count), 64'(3));
    drain();

    // Back-pressure: only two beats fit
    bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = 3'd0;
      bus.in_data  = 32'h0000_0100 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 64'(acc_cnt - acc0), 64'(2));
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    held = bus.out_data;
    tick();
    chk("bp_stable", 64'(bus.out_data), 64'(held));
    drain();

    // Random traffic with a mid-stream reset
    acc0 = acc_cnt;
    cyc = 0;
    did_rst = 0;
    while ((acc_cnt - acc0) < 10000 && cyc < 60000) begin
      if (!did_rst && (acc_cnt - acc0) >= 5000) begin
        did_rst = 1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_err_count", 64'(err_count), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        err_model = '0;
      end
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      bus.in_mode   = 3'($urandom_range(7));
      bus.in_data   = $urandom;
      bus.in_off    = 2'($urandom_range(3));
      tick();
      cyc++;
    end
    if ((acc_cnt - acc0) < 10000) chk("random_timeout", 64'(acc_cnt - acc0), 64'(10000));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
